// File: rtl/arima_frame_loader.sv
// ARIMA front-end: parses a word-serial frame (header, constant, AR/MA banks, samples)
// and forwards the samples through a one-entry output register with backpressure.
module arima_frame_loader #(
    parameter int N         = 32,
    parameter int Q         = 15,
    parameter int MAX_ORDER = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [31:0]         p_order,
    output logic [31:0]         d_order,
    output logic [31:0]         q_order,
    output logic signed [N-1:0] cont,
    output logic signed [N-1:0] ar_coef [0:MAX_ORDER-1],
    output logic signed [N-1:0] ma_coef [0:MAX_ORDER-1],
    output logic                cfg_valid,
    output logic                cfg_error,
    output logic signed [N-1:0] sample_data,
    output logic                sample_valid,
    output logic                sample_last,
    input  logic                sample_ready,
    output logic [15:0]         sample_count
);

    // Q only documents the fixed-point format; values are never rescaled here.
    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("arima_frame_loader: Q must lie in [0, N)");
    end

    typedef enum logic [2:0] {IDLE, CONT, AR, MA, STREAM, DRAIN} state_t;

    localparam logic [3:0] ORD_MAX = 4'(MAX_ORDER);

    state_t     state;
    state_t     state_next;
    logic [3:0] p_reg;
    logic [3:0] d_reg;
    logic [3:0] q_reg;
    logic [3:0] idx;
    logic       in_xfer;
    logic       out_xfer;
    logic       hdr_ok;
    logic       cfg_done;

    assign in_ready = !rst && ((state != STREAM) || !sample_valid || sample_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = sample_valid && sample_ready;

    assign hdr_ok = (in_data[31:24] == 8'hA5) && (in_data[11:8] <= ORD_MAX)
                 && (in_data[7:4] <= ORD_MAX) && (in_data[3:0] <= ORD_MAX);

    assign p_order = {28'd0, p_reg};
    assign d_order = {28'd0, d_reg};
    assign q_order = {28'd0, q_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // cfg_done flags the transfer of the final configuration word of a well-formed frame.
    always_comb begin
        state_next = state;
        cfg_done   = 1'b0;
        case (state)
            IDLE: begin
                if (in_xfer) begin
                    if (hdr_ok)       state_next = CONT;
                    else if (!in_last) state_next = DRAIN;
                end
            end
            CONT: begin
                if (in_xfer) begin
                    if (in_last)             state_next = IDLE;
                    else if (p_reg != 4'd0)  state_next = AR;
                    else if (q_reg != 4'd0)  state_next = MA;
                    else begin
                        state_next = STREAM;
                        cfg_done   = 1'b1;
                    end
                end
            end
            AR: begin
                if (in_xfer) begin
                    if (in_last) begin
                        state_next = IDLE;
                    end else if (idx == p_reg - 4'd1) begin
                        if (q_reg != 4'd0) begin
                            state_next = MA;
                        end else begin
                            state_next = STREAM;
                            cfg_done   = 1'b1;
                        end
                    end
                end
            end
            MA: begin
                if (in_xfer) begin
                    if (in_last) begin
                        state_next = IDLE;
                    end else if (idx == q_reg - 4'd1) begin
                        state_next = STREAM;
                        cfg_done   = 1'b1;
                    end
                end
            end
            STREAM, DRAIN: begin
                if (in_xfer && in_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Configuration registers; a word carrying in_last mid-config marks the frame truncated.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg        <= '0;
            d_reg        <= '0;
            q_reg        <= '0;
            idx          <= '0;
            cont         <= '0;
            cfg_valid    <= 1'b0;
            cfg_error    <= 1'b0;
            sample_count <= '0;
            for (int i = 0; i < MAX_ORDER; i++) begin
                ar_coef[i] <= '0;
                ma_coef[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        if (hdr_ok) begin
                            p_reg        <= in_data[11:8];
                            d_reg        <= in_data[7:4];
                            q_reg        <= in_data[3:0];
                            idx          <= '0;
                            cfg_valid    <= 1'b0;
                            cfg_error    <= 1'b0;
                            sample_count <= '0;
                            for (int i = 0; i < MAX_ORDER; i++) begin
                                ar_coef[i] <= '0;
                                ma_coef[i] <= '0;
                            end
                        end else begin
                            cfg_error <= 1'b1;
                        end
                    end
                end
                CONT: begin
                    if (in_xfer) begin
                        if (in_last) cfg_error <= 1'b1;
                        else         cont      <= in_data;
                        idx <= '0;
                    end
                end
                AR: begin
                    if (in_xfer) begin
                        if (in_last) begin
                            cfg_error <= 1'b1;
                        end else begin
                            ar_coef[idx] <= in_data;
                            idx          <= (idx == p_reg - 4'd1) ? 4'd0 : idx + 4'd1;
                        end
                    end
                end
                MA: begin
                    if (in_xfer) begin
                        if (in_last) begin
                            cfg_error <= 1'b1;
                        end else begin
                            ma_coef[idx] <= in_data;
                            idx          <= idx + 4'd1;
                        end
                    end
                end
                STREAM: begin
                    if (in_xfer && sample_count != 16'hFFFF) begin
                        sample_count <= sample_count + 16'd1;
                    end
                end
                default: ;
            endcase
            if (cfg_done) cfg_valid <= 1'b1;
        end
    end

    // Output register: a load in the same cycle as an unload keeps sample_valid asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
            sample_last  <= 1'b0;
        end else if (state == STREAM && in_xfer) begin
            sample_data  <= in_data;
            sample_valid <= 1'b1;
            sample_last  <= in_last;
        end else if (out_xfer) begin
            sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arima_frame_loader.sv
// Scoreboard bench for arima_frame_loader: drivers push expected samples/configs into queues,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_arima_frame_loader;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [31:0]        p_order;
    logic [31:0]        d_order;
    logic [31:0]        q_order;
    logic signed [31:0] cont;
    logic signed [31:0] ar_coef [0:9];
    logic signed [31:0] ma_coef [0:9];
    logic               cfg_valid;
    logic               cfg_error;
    logic signed [31:0] sample_data;
    logic               sample_valid;
    logic               sample_last;
    logic               sample_ready;
    logic [15:0]        sample_count;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } samp_t;

    typedef struct packed {
        logic [3:0]       p;
        logic [3:0]       d;
        logic [3:0]       q;
        logic [31:0]      cont;
        logic [9:0][31:0] ar;
        logic [9:0][31:0] ma;
    } cfg_t;

    samp_t       sq[$];
    cfg_t        cq[$];
    cfg_t        model;
    logic [31:0] frame_cfg[$];
    logic [31:0] frame_smp[$];
    bit          stream_phase = 1'b0;
    bit          exp_cfg_valid = 1'b0;
    bit          mon_en = 1'b0;
    int          ready_mode = 0;
    int          pat_idx = 0;
    bit          pat [0:7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int          n_checks = 0;
    int          n_pass = 0;

    arima_frame_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .p_order      (p_order),
        .d_order      (d_order),
        .q_order      (q_order),
        .cont         (cont),
        .ar_coef      (ar_coef),
        .ma_coef      (ma_coef),
        .cfg_valid    (cfg_valid),
        .cfg_error    (cfg_error),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_last  (sample_last),
        .sample_ready (sample_ready),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_cfg(input cfg_t e, input string tag);
        checkOutput({tag, "_p"}, p_order, 32'(e.p));
        checkOutput({tag, "_d"}, d_order, 32'(e.d));
        checkOutput({tag, "_q"}, q_order, 32'(e.q));
        checkOutput({tag, "_cont"}, cont, e.cont);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("%s_ar%0d", tag, i), ar_coef[i], e.ar[i]);
            checkOutput($sformatf("%s_ma%0d", tag, i), ma_coef[i], e.ma[i]);
        end
    endtask

    // Offer one word starting at posedge+1; returns at posedge+1 after it is accepted.
    task automatic send_word(input logic [31:0] data, input logic last, output bit ok);
        bit acc;
        in_data  = data;
        in_last  = last;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("[TB] FAIL handshake_timeout: word %h never accepted", data);
        end
    endtask

    task automatic fill_random(input int p, input int d, input int q, input int nsamp, output logic [31:0] hdr);
        frame_cfg.delete();
        frame_smp.delete();
        for (int i = 0; i < 1 + p + q; i++) frame_cfg.push_back($urandom);
        for (int i = 0; i < nsamp; i++) frame_smp.push_back($urandom);
        hdr = {8'hA5, 12'($urandom), 4'(p), 4'(d), 4'(q)};
    endtask

    // Sends a valid-header frame from frame_cfg/frame_smp; trunc_at >= 0 puts in_last on that config word.
    task automatic applyStimulus(input logic [31:0] hdr, input int trunc_at);
        bit    ok;
        int    p;
        samp_t s;
        p = int'(hdr[11:8]);
        send_word(hdr, 1'b0, ok);
        if (!ok) return;
        model.p       = hdr[11:8];
        model.d       = hdr[7:4];
        model.q       = hdr[3:0];
        model.ar      = '0;
        model.ma      = '0;
        exp_cfg_valid = 1'b0;
        for (int i = 0; i < frame_cfg.size(); i++) begin
            send_word(frame_cfg[i], 1'(i == trunc_at), ok);
            if (!ok) return;
            if (i == trunc_at) begin
                @(negedge clk);
                checkOutput("trunc_cfg_error", 32'(cfg_error), 32'd1);
                checkOutput("trunc_cfg_valid", 32'(cfg_valid), 32'd0);
                @(posedge clk);
                #1;
                return;
            end
            if (i == 0)      model.cont        = frame_cfg[i];
            else if (i <= p) model.ar[i-1]     = frame_cfg[i];
            else             model.ma[i-1-p]   = frame_cfg[i];
            if (i == frame_cfg.size() - 1) begin
                cq.push_back(model);
                exp_cfg_valid = 1'b1;
                stream_phase  = 1'b1;
            end
        end
        for (int k = 0; k < frame_smp.size(); k++) begin
            send_word(frame_smp[k], 1'(k == frame_smp.size() - 1), ok);
            if (!ok) return;
            s.data = frame_smp[k];
            s.last = 1'(k == frame_smp.size() - 1);
            sq.push_back(s);
            if (s.last) stream_phase = 1'b0;
        end
        @(negedge clk);
        checkOutput("frame_sample_count", 32'(sample_count), 32'(frame_smp.size()));
        checkOutput("frame_cfg_valid", 32'(cfg_valid), 32'd1);
        checkOutput("frame_cfg_error", 32'(cfg_error), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_bad(input logic [31:0] hdr, input logic hdr_last, input int nextra);
        bit ok;
        send_word(hdr, hdr_last, ok);
        @(negedge clk);
        checkOutput("bad_hdr_cfg_error", 32'(cfg_error), 32'd1);
        checkOutput("bad_hdr_cfg_valid", 32'(cfg_valid), 32'(exp_cfg_valid));
        @(posedge clk);
        #1;
        for (int k = 0; k < nextra; k++) send_word($urandom, 1'(k == nextra - 1), ok);
        @(negedge clk);
        check_cfg(model, "hold");
        checkOutput("hold_cfg_error", 32'(cfg_error), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        stream_phase = 1'b0;
        sq.delete();
        cq.delete();
        model         = '0;
        exp_cfg_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_cfg(model, "rst");
        checkOutput("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        checkOutput("rst_cfg_error", 32'(cfg_error), 32'd0);
        checkOutput("rst_sample_valid", 32'(sample_valid), 32'd0);
        checkOutput("rst_sample_last", 32'(sample_last), 32'd0);
        checkOutput("rst_sample_data", sample_data, 32'd0);
        checkOutput("rst_sample_count", 32'(sample_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: sample_ready = 1'b1;
                1: begin
                    sample_ready = pat[pat_idx % 8];
                    pat_idx++;
                end
                default: sample_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: expected in_ready comes from scoreboard occupancy, samples/configs from the queues.
    always @(negedge clk) begin
        samp_t s;
        cfg_t  e;
        if (!rst && mon_en) begin
            checkOutput("in_ready", 32'(in_ready),
                        32'(stream_phase ? (sq.size() == 0 || sample_ready) : 1'b1));
            checkOutput("sample_valid", 32'(sample_valid), 32'(sq.size() != 0));
            if (sample_valid && sq.size() > 0) begin
                s = sq[0];
                checkOutput("sample_data", sample_data, s.data);
                checkOutput("sample_last", 32'(sample_last), 32'(s.last));
                if (sample_ready) void'(sq.pop_front());
            end
            if (cq.size() > 0) begin
                e = cq.pop_front();
                checkOutput("cfg_valid_rise", 32'(cfg_valid), 32'd1);
                check_cfg(e, "cfg");
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] hdr;
        bit          ok;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        in_data      = '0;
        sample_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;

        $display("[TB] directed frame p=3 d=2 q=1");
        frame_cfg = '{32'h0000_8000, 32'h0000_4000, 32'hFFFF_C000, 32'h0000_2000, 32'h0000_1000};
        frame_smp = '{32'd1, 32'd2, 32'd3};
        applyStimulus(32'hA500_0321, -1);

        $display("[TB] p=0 q=0 frame");
        fill_random(0, 4, 0, 2, hdr);
        applyStimulus(hdr, -1);

        $display("[TB] bad sync header then drain");
        send_bad(32'h5A00_0321, 1'b0, 4);
        fill_random(1, 0, 2, 2, hdr);
        applyStimulus(hdr, -1);

        $display("[TB] p=11 header");
        send_bad(32'hA500_0B21, 1'b0, 2);
        $display("[TB] invalid header carrying in_last");
        send_bad(32'hA500_01C1, 1'b1, 0);
        fill_random(2, 1, 1, 1, hdr);
        applyStimulus(hdr, -1);

        $display("[TB] truncated on second AR word");
        fill_random(3, 0, 1, 2, hdr);
        applyStimulus(hdr, 2);

        $display("[TB] stall pattern 1,0,0,1,1,0,1,1");
        ready_mode = 1;
        fill_random(2, 1, 2, 8, hdr);
        applyStimulus(hdr, -1);

        $display("[TB] reset during AR phase");
        ready_mode = 0;
        send_word(32'hA500_0532, 1'b0, ok);
        send_word($urandom, 1'b0, ok);
        send_word($urandom, 1'b0, ok);
        do_reset();
        fill_random(5, 3, 2, 3, hdr);
        applyStimulus(hdr, -1);

        $display("[TB] random frames with random sample_ready");
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            fill_random(int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                        int'($urandom_range(0, 10)), int'($urandom_range(1, 6)), hdr);
            applyStimulus(hdr, -1);
        end

        ready_mode = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (sq.size() == 0) break;
        end
        checkOutput("drain_empty", 32'(sq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
